net_activity: RTL and testbench
===============================

NET_ACTIVITY -- requirements
Module: net_activity

Interface
REQ-001 Parameter NLINKS, default 4: number of Ethernet links served.
REQ-002 Parameter TICK_DIV, default 100000: i_clk cycles per timebase tick (1 ms at 100 MHz); legal range 2..2^24.
REQ-003 Parameter ACT_ON, default 30: activity LED on-phase length in ticks; legal range 1..255.
REQ-004 Parameter ACT_OFF, default 30: forced dark gap after each on-phase, in ticks; legal range 1..255.
REQ-005 Parameter LINK_STABLE, default 200: ticks link-up must hold before the LED lights; legal range 1..255.
REQ-006 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 i_reset_n  input  1  asynchronous, active-low reset.
REQ-008 i_link_up  input  NLINKS  per-link PHY/PCS link status, synchronous to i_clk.
REQ-009 i_rx_valid  input  NLINKS  per-link receive-packet strobe, any width of pulse, synchronous.
REQ-010 i_tx_valid  input  NLINKS  per-link transmit-packet strobe, synchronous.
REQ-011 o_linkup  output  NLINKS  registered link LED drive, same meaning as the LED sequencer's o_linkup.
REQ-012 o_activity  output  NLINKS  registered activity LED drive, same meaning as the LED sequencer's o_activity.

Function
REQ-013 Shared prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle internal tick on the cycle it wraps to 0.
REQ-014 Per link, event = i_rx_valid[n] | i_tx_valid[n], sampled every cycle (not only on ticks).
REQ-015 Link qualifier: while i_link_up[n]=0, stable counter SHALL be 0 and o_linkup[n] SHALL be 0 on the next cycle.
REQ-016 While i_link_up[n]=1, stable counter SHALL increment on each tick, saturating at LINK_STABLE; o_linkup[n] SHALL be 1 from the cycle after it reaches LINK_STABLE.
REQ-017 Link drop: o_linkup[n] SHALL fall exactly one cycle after i_link_up[n] falls, regardless of tick phase; a one-cycle drop restarts qualification.
REQ-018 Activity FSM per link, states IDLE, ON, OFF; 8-bit phase counter; pending flag.
REQ-019 IDLE: on event while o_linkup[n]=1 -> ON, counter cleared, o_activity[n]=1 next cycle.
REQ-020 ON: counter increments per tick; on the tick making it equal ACT_ON -> OFF, counter cleared, o_activity[n]=0 next cycle.
REQ-021 OFF: counter increments per tick; on the tick making it equal ACT_OFF -> ON if pending else IDLE; pending cleared on that transition.
REQ-022 Events during ON or OFF SHALL set pending; an event coinciding with the OFF exit tick SHALL count as pending (-> ON).
REQ-023 Continuous traffic SHALL therefore blink with ACT_ON ticks on / ACT_OFF ticks off; a single event SHALL give exactly one on-phase.
REQ-024 On-phase length SHALL be between (ACT_ON-1)*TICK_DIV+1 and ACT_ON*TICK_DIV cycles, depending on tick phase at entry.
REQ-025 Whenever o_linkup[n]=0 (including a drop mid-ON/OFF) the FSM SHALL return to IDLE, clear counter and pending, and drive o_activity[n]=0 next cycle; events are ignored.
REQ-026 Links SHALL be fully independent except for the shared prescaler.

Reset
REQ-027 i_reset_n low SHALL immediately (asynchronously) force o_linkup=0, o_activity=0, prescaler=0, all stable/phase counters=0, pending=0, FSMs=IDLE.
REQ-028 Reset asserted mid-operation SHALL discard all in-progress phases; after release, link qualification restarts from 0.
REQ-029 After release, first tick SHALL occur TICK_DIV cycles after the first active clock edge.

Verification (TICK_DIV=4, ACT_ON=2, ACT_OFF=2, LINK_STABLE=3)
REQ-030 Link qualify: i_link_up[0]=1 held from reset release -> o_linkup[0] rises after 3rd tick (cycle 13), others stay 0.
REQ-031 Link glitch: drop i_link_up[0] for 1 cycle after qualification -> o_linkup[0]=0 next cycle, re-rises 3 ticks later.
REQ-032 Single event: one-cycle i_rx_valid[1] on qualified link -> o_activity[1] high 5..8 cycles, then 0 with FSM IDLE.
REQ-033 Continuous traffic: i_tx_valid[2]=1 for 40 cycles -> o_activity[2] alternates 2 ticks on / 2 ticks off, ends with one extra on-phase then IDLE.
REQ-034 Drop during ON: deassert i_link_up[3] mid on-phase -> both o_linkup[3] and o_activity[3] 0 next cycle; events ignored until requalified.
REQ-035 Async reset mid-blink: pulse i_reset_n low between edges -> all outputs 0 immediately, before next i_clk edge.

Source files
------------

// File: rtl/net_activity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : net_activity
// Description : Per-link Ethernet LED driver. A shared prescaler produces a
//               slow timebase tick. Each link has a link-stable qualifier
//               that drives the link LED, and a blink sequencer that turns
//               packet strobes into visible activity flashes with a forced
//               dark gap between flashes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk       in   1       sole clock, rising edge
//   i_reset_n   in   1       asynchronous active-low reset
//   i_link_up   in   NLINKS  per-link PHY/PCS link status (synchronous)
//   i_rx_valid  in   NLINKS  per-link receive-packet strobe (synchronous)
//   i_tx_valid  in   NLINKS  per-link transmit-packet strobe (synchronous)
//   o_linkup    out  NLINKS  registered link LED drive
//   o_activity  out  NLINKS  registered activity LED drive
// ============================================================================
module net_activity #(
    parameter int NLINKS      = 4,
    parameter int TICK_DIV    = 100000,
    parameter int ACT_ON      = 30,
    parameter int ACT_OFF     = 30,
    parameter int LINK_STABLE = 200
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NLINKS-1:0] i_link_up,
    input  logic [NLINKS-1:0] i_rx_valid,
    input  logic [NLINKS-1:0] i_tx_valid,
    output logic [NLINKS-1:0] o_linkup,
    output logic [NLINKS-1:0] o_activity
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] C_PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [7:0]         C_ACT_ON      = 8'(ACT_ON);
    localparam logic [7:0]         C_ACT_OFF     = 8'(ACT_OFF);
    localparam logic [7:0]         C_LINK_STABLE = 8'(LINK_STABLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } act_state_t;

    // ------------------------------------------------------------------------
    // Shared prescaler. The tick is the cycle whose rising edge wraps the
    // counter back to 0, so every per-link tick action happens on that same
    // edge. Out of reset the first wrap is on the TICK_DIV-th edge.
    // ------------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    assign tick = (presc_cnt == C_PRESC_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-link logic. Links share nothing but the tick.
    // ------------------------------------------------------------------------
    for (genvar n = 0; n < NLINKS; n++) begin : g_link

        logic       pkt_event;
        logic [7:0] stable_cnt;
        logic       qual_next;
        logic       linkup_q;
        act_state_t state;
        logic [7:0] phase_cnt;
        logic       pending;
        logic       activity_q;

        // Events are sampled every cycle, not only on ticks.
        assign pkt_event = i_rx_valid[n] | i_tx_valid[n];

        // Value o_linkup will take on the next edge. Dropping i_link_up kills
        // it immediately, independent of the tick phase.
        assign qual_next = i_link_up[n] & (stable_cnt == C_LINK_STABLE);

        // Link qualifier: count ticks of continuous link-up, saturating.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                stable_cnt <= '0;
                linkup_q   <= 1'b0;
            end else begin
                if (!i_link_up[n]) begin
                    stable_cnt <= '0;
                end else if (tick && (stable_cnt != C_LINK_STABLE)) begin
                    stable_cnt <= stable_cnt + 8'd1;
                end
                linkup_q <= qual_next;
            end
        end

        // Activity blink sequencer. It is gated by qual_next rather than the
        // registered link LED so that a link drop clears both LEDs on the
        // same edge. Entry from IDLE still requires the link LED to already
        // be lit.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state      <= ST_IDLE;
                phase_cnt  <= '0;
                pending    <= 1'b0;
                activity_q <= 1'b0;
            end else if (!qual_next) begin
                state      <= ST_IDLE;
                phase_cnt  <= '0;
                pending    <= 1'b0;
                activity_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pkt_event && linkup_q) begin
                            state      <= ST_ON;
                            phase_cnt  <= '0;
                            activity_q <= 1'b1;
                        end
                    end

                    ST_ON: begin
                        if (pkt_event) begin
                            pending <= 1'b1;
                        end
                        if (tick) begin
                            if ((phase_cnt + 8'd1) == C_ACT_ON) begin
                                state      <= ST_OFF;
                                phase_cnt  <= '0;
                                activity_q <= 1'b0;
                            end else begin
                                phase_cnt <= phase_cnt + 8'd1;
                            end
                        end
                    end

                    ST_OFF: begin
                        if (tick && ((phase_cnt + 8'd1) == C_ACT_OFF)) begin
                            // An event landing on the exit tick counts as
                            // pending and starts the next flash directly.
                            phase_cnt <= '0;
                            pending   <= 1'b0;
                            if (pending || pkt_event) begin
                                state      <= ST_ON;
                                activity_q <= 1'b1;
                            end else begin
                                state      <= ST_IDLE;
                                activity_q <= 1'b0;
                            end
                        end else begin
                            if (pkt_event) begin
                                pending <= 1'b1;
                            end
                            if (tick) begin
                                phase_cnt <= phase_cnt + 8'd1;
                            end
                        end
                    end

                    default: begin
                        state      <= ST_IDLE;
                        phase_cnt  <= '0;
                        pending    <= 1'b0;
                        activity_q <= 1'b0;
                    end
                endcase
            end
        end

        assign o_linkup[n]   = linkup_q;
        assign o_activity[n] = activity_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_net_activity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_net_activity
// Description : Scoreboard bench for net_activity with TICK_DIV=4, ACT_ON=2,
//               ACT_OFF=2, LINK_STABLE=3. Stimulus code queues the expected
//               LED vectors for given cycles (counted in rising edges since
//               reset release); a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_net_activity;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL-1:0] link_up;
    logic [NL-1:0] rx_valid;
    logic [NL-1:0] tx_valid;
    logic [NL-1:0] linkup;
    logic [NL-1:0] activity;

    always #5 clk = ~clk;

    net_activity #(
        .NLINKS      (NL),
        .TICK_DIV    (4),
        .ACT_ON      (2),
        .ACT_OFF     (2),
        .LINK_STABLE (3)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_link_up  (link_up),
        .i_rx_valid (rx_valid),
        .i_tx_valid (tx_valid),
        .o_linkup   (linkup),
        .o_activity (activity)
    );

    typedef struct {
        string          tag;
        int             cyc;
        bit             is_act;
        logic [NL-1:0]  exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int edge_count = 0;
    int base       = 0;
    int tests      = 0;
    int failures   = 0;

    // Single-event and pending-on-exit-tick sequence on link 1
    int            c_cyc [14] = '{40, 41, 47, 48, 55, 56, 57, 63, 64, 71, 72, 79, 80, 90};
    logic [NL-1:0] c_exp [14] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2,
                                  4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};

    // Continuous traffic on link 2: 2 ticks on / 2 ticks off, one extra flash
    int            d_cyc [18] = '{92, 93, 99, 100, 107, 108, 115, 116, 123, 124,
                                  131, 132, 139, 140, 147, 148, 157, 160};
    logic [NL-1:0] d_exp [18] = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0,
                                  4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic check_val(input string tag, input logic [NL-1:0] got,
                             input logic [NL-1:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic expect_at(input string tag, input int rel, input bit is_act,
                             input logic [NL-1:0] exp);
        sb_entry_t e;
        e.tag    = tag;
        e.cyc    = base + rel;
        e.is_act = is_act;
        e.exp    = exp;
        sb_q.push_back(e);
    endtask

    // Returns #1 after the rising edge numbered rel (relative to release).
    task automatic wait_until(input int rel);
        while (edge_count < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin
        sb_entry_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_count) begin
            e = sb_q.pop_front();
            check_val(e.tag, e.is_act ? activity : linkup, e.exp);
        end
    end

    initial begin
        rst_n    = 1'b0;
        link_up  = 4'b0001;
        rx_valid = 4'hF;
        tx_valid = 4'hF;

        // Reset state, with strobes active to show reset dominates
        expect_at("rst_link", 2, 1'b0, 4'h0);
        expect_at("rst_act",  2, 1'b1, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rx_valid = '0;
        tx_valid = '0;
        rst_n    = 1'b1;
        base     = edge_count;

        // Link 0 qualifies after the 3rd tick; others stay dark
        expect_at("qual_before", 12, 1'b0, 4'h1 & 4'h0);
        expect_at("qual_rise",   13, 1'b0, 4'h1);
        expect_at("qual_others", 24, 1'b0, 4'h1);
        expect_at("qual_all",    25, 1'b0, 4'hF);
        wait_until(13);
        link_up = 4'hF;

        // One-cycle glitch on link 0
        expect_at("glitch_pre",   26, 1'b0, 4'hF);
        expect_at("glitch_drop",  27, 1'b0, 4'hE);
        expect_at("glitch_requal_wait", 36, 1'b0, 4'hE);
        expect_at("glitch_requal", 37, 1'b0, 4'hF);
        wait_until(26);
        link_up[0] = 1'b0;
        wait_until(27);
        link_up[0] = 1'b1;

        // Single event, re-trigger from IDLE, event on the OFF exit tick
        for (int i = 0; i < 14; i++) begin
            expect_at($sformatf("single_act_c%0d", c_cyc[i]), c_cyc[i], 1'b1, c_exp[i]);
        end
        expect_at("single_link", 90, 1'b0, 4'hF);
        wait_until(40);  rx_valid[1] = 1'b1;
        wait_until(41);  rx_valid[1] = 1'b0;
        wait_until(56);  rx_valid[1] = 1'b1;
        wait_until(57);  rx_valid[1] = 1'b0;
        wait_until(71);  rx_valid[1] = 1'b1;
        wait_until(72);  rx_valid[1] = 1'b0;

        // Continuous tx traffic on link 2 for 40 cycles
        for (int i = 0; i < 18; i++) begin
            expect_at($sformatf("cont_act_c%0d", d_cyc[i]), d_cyc[i], 1'b1, d_exp[i]);
        end
        wait_until(92);  tx_valid[2] = 1'b1;
        wait_until(132); tx_valid[2] = 1'b0;

        // Link 3 drops mid on-phase; events ignored until requalified
        expect_at("drop_on",        161, 1'b1, 4'h8);
        expect_at("drop_on_late",   163, 1'b1, 4'h8);
        expect_at("drop_link_pre",  163, 1'b0, 4'hF);
        expect_at("drop_link",      164, 1'b0, 4'h7);
        expect_at("drop_act",       164, 1'b1, 4'h0);
        expect_at("drop_ign_a",     165, 1'b1, 4'h0);
        expect_at("drop_ign_b",     170, 1'b1, 4'h0);
        expect_at("drop_requal_wait", 176, 1'b0, 4'h7);
        expect_at("drop_requal",    177, 1'b0, 4'hF);
        expect_at("drop_ign_c",     177, 1'b1, 4'h0);
        expect_at("drop_restart",   178, 1'b1, 4'h8);
        expect_at("drop_restart_hold", 183, 1'b1, 4'h8);
        expect_at("drop_restart_off",  184, 1'b1, 4'h0);
        wait_until(160); rx_valid[3] = 1'b1;
        wait_until(161); rx_valid[3] = 1'b0;
        wait_until(163); link_up[3]  = 1'b0;
        wait_until(164); rx_valid[3] = 1'b1;
        wait_until(165); link_up[3]  = 1'b1;
        wait_until(178); rx_valid[3] = 1'b0;

        // Asynchronous reset mid-blink on link 0
        expect_at("blink_pre",     189, 1'b1, 4'h0);
        expect_at("blink_on",      190, 1'b1, 4'h1);
        expect_at("blink_hold",    191, 1'b1, 4'h1);
        expect_at("blink_link",    191, 1'b0, 4'hF);
        expect_at("arst_link",     192, 1'b0, 4'h0);
        expect_at("arst_act",      192, 1'b1, 4'h0);
        wait_until(189); rx_valid[0] = 1'b1;
        wait_until(190); rx_valid[0] = 1'b0;
        wait_until(192);
        #1 rst_n = 1'b0;   // between edges; the negedge sample must see zeros
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = edge_count;

        // Blink discarded; qualification restarts from zero
        expect_at("post_rst_act",        1, 1'b1, 4'h0);
        expect_at("post_rst_link",       1, 1'b0, 4'h0);
        expect_at("post_rst_qual_wait", 12, 1'b0, 4'h0);
        expect_at("post_rst_qual",      13, 1'b0, 4'hF);
        expect_at("post_rst_act_idle",  13, 1'b1, 4'h0);
        wait_until(16);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
